// File: rtl/mskaes_32bits_key_loader.sv
// Masked AES key loader: collects 4/6/8 shared 32-bit columns into a
// 256-bit-per-share key register and hands it off with a valid/ready pair.
module mskaes_32bits_key_loader #(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_256,
  input  logic               mode_192,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*d-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [256*d-1:0]   sh_key,
  output logic               out_mode_256,
  output logic               out_mode_192,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                     state_q;
  logic [2:0]                 cnt_q;
  logic [2:0]                 last_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       m256_q;
  logic                       m192_q;
  logic [7:0][32*d-1:0]       key_q;

  logic beat;
  assign beat = in_valid & in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      last_q      <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      m256_q      <= 1'b0;
      m192_q      <= 1'b0;
      key_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q    <= LOAD;
          cnt_q      <= 3'd0;
          in_ready_q <= 1'b1;
          m256_q     <= mode_256;
          m192_q     <= mode_192 & ~mode_256;
          last_q     <= mode_256 ? 3'd7 : (mode_192 ? 3'd5 : 3'd3);
          key_q      <= '0;
        end
        LOAD: if (beat) begin
          // Columns are only ever register-written whole; shares never mix.
          key_q[cnt_q] <= in_data;
          if (cnt_q == last_q) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign sh_key       = key_q;
  assign out_mode_256 = m256_q;
  assign out_mode_192 = m192_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mskaes_32bits_key_loader.sv
// Bench for the masked key loader: table of load scenarios plus reset and
// spurious-input sequences, expected keys held in a scoreboard queue.
module tb_mskaes_32bits_key_loader;
  localparam int D  = 2;
  localparam int KW = 256*D;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, mode_256, mode_192, in_valid, out_ready;
  logic [32*D-1:0] in_data;
  logic            in_ready, out_valid, out_mode_256, out_mode_192, busy;
  logic [KW-1:0]   sh_key;

  mskaes_32bits_key_loader #(.d(D)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_256(mode_256), .mode_192(mode_192),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .sh_key(sh_key),
    .out_mode_256(out_mode_256), .out_mode_192(out_mode_192), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m256; bit m192; bit gaps; bit spur; int bp; bit em256; bit em192; bit fips;
  } vec_t;

  vec_t          vecs[5];
  logic [31:0]   fips[4];
  logic [KW-1:0] exp_q[$];
  logic [KW-1:0] last_key;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Split each byte into D random shares whose XOR is the plain byte.
  function automatic logic [32*D-1:0] share_col(input logic [31:0] w);
    logic [32*D-1:0] col;
    logic [7:0] acc, r;
    col = '0;
    for (int b = 0; b < 4; b++) begin
      acc = w[8*b +: 8];
      for (int s = 0; s < D-1; s++) begin
        r = 8'($urandom);
        col[8*D*b + 8*s +: 8] = r;
        acc = acc ^ r;
      end
      col[8*D*b + 8*(D-1) +: 8] = acc;
    end
    return col;
  endfunction

  task automatic do_load(input vec_t v);
    int n;
    logic [KW-1:0] exp;
    logic [32*D-1:0] col;
    logic [31:0] w;
    n = v.m256 ? 8 : (v.m192 ? 6 : 4);
    start = 1; mode_256 = v.m256; mode_192 = v.m192;
    tick();
    start = 0; mode_256 = 0; mode_192 = 0;
    chk("start_flags", {busy, in_ready, out_valid}, 3'b110);
    chk("start_clear", sh_key, '0);
    exp = '0;
    for (int i = 0; i < n; i++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 0; in_data = 64'($urandom); tick();
        end
      end
      w = v.fips ? fips[i] : $urandom;
      col = share_col(w);
      in_valid = 1; in_data = col;
      exp[32*D*i +: 32*D] = col;
      tick();
      in_valid = 0;
      if (i < n-1) chk("mid_load", {out_valid, in_ready, busy}, 3'b011);
      if (v.spur && i == 0) begin
        start = 1; mode_256 = 1;
        tick();
        start = 0; mode_256 = 0;
        chk("spur_start_key", sh_key, exp);
        chk("spur_start_flags", {out_valid, in_ready, busy}, 3'b011);
      end
    end
    exp_q.push_back(exp);
    chk("done_flags", {out_valid, in_ready, busy}, 3'b101);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      chk("key", sh_key, exp);
      chk("modes", {out_mode_256, out_mode_192}, {v.em256, v.em192});
      repeat (v.bp) begin
        tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_key", sh_key, exp);
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("idle_flags", {out_valid, in_ready, busy}, 3'b000);
      chk("retain_key", sh_key, exp);
      chk("retain_modes", {out_mode_256, out_mode_192}, {v.em256, v.em192});
      last_key = exp;
    end
  endtask

  initial begin
    fips[0] = 32'h2b7e1516; fips[1] = 32'h28aed2a6;
    fips[2] = 32'habf71588; fips[3] = 32'h09cf4f3c;
    //          m256 m192 gaps spur bp em256 em192 fips
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0};

    rst = 1; start = 0; mode_256 = 0; mode_192 = 0;
    in_valid = 0; out_ready = 0; in_data = '0;
    tick(); tick();
    chk("reset_flags", {in_ready, out_valid, busy, out_mode_256, out_mode_192}, 5'b0);
    chk("reset_key", sh_key, '0);
    rst = 0;
    tick();

    for (int k = 0; k < 5; k++) do_load(vecs[k]);

    // Beats presented while idle must not touch the held key.
    repeat (3) begin
      in_valid = 1; in_data = share_col($urandom);
      tick();
    end
    in_valid = 0;
    chk("idle_beat_key", sh_key, last_key);
    chk("idle_beat_flags", {in_ready, out_valid, busy}, 3'b000);

    // Asynchronous reset in the middle of an AES-192 load.
    start = 1; mode_192 = 1;
    tick();
    start = 0; mode_192 = 0;
    repeat (2) begin
      in_valid = 1; in_data = share_col($urandom | 32'h1);
      tick();
    end
    in_valid = 0;
    chk("pre_rst_mode", {out_mode_256, out_mode_192, busy}, 3'b011);
    #2 rst = 1;
    #1;
    chk("rst_async_flags", {in_ready, out_valid, busy, out_mode_256, out_mode_192}, 5'b0);
    chk("rst_async_key", sh_key, '0);
    #2 rst = 0;
    tick();
    in_valid = 1; in_data = share_col($urandom | 32'h1);
    tick();
    in_valid = 0;
    chk("post_rst_beat_key", sh_key, '0);
    chk("post_rst_beat_flags", {in_ready, out_valid, busy}, 3'b000);

    do_load(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
